// File: rtl/d_branch_unit.sv
// D-stage branch resolver: six-mode operand compare plus a table of 2-bit
// saturating counters that predicts, trains and counts branches/mispredicts.
module d_branch_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic             stall,
  input  logic [31:0]      d_pc,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       btype,
  output logic             cmp_result,
  output logic             pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [1:0] {SN = 2'b00, WN = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

  ctr_t              bht [BHT_DEPTH];
  ctr_t              cur_entry;
  ctr_t              next_entry;
  logic [IDX_W-1:0]  idx;
  logic              is_br;
  logic              upd;
  logic              rs_neg;
  logic              rs_zero;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{d_pc[31:IDX_W+2], d_pc[1:0]};

  assign idx     = d_pc[IDX_W+1:2];
  assign rs_neg  = rs[WIDTH-1];
  assign rs_zero = (rs == '0);
  assign is_br   = (btype != 3'b000) && (btype != 3'b111);
  assign upd     = reset && d_valid && !stall && is_br;

  // Signed zero tests reduce to the sign bit plus an all-zero check.
  always_comb begin
    cmp_result = 1'b0;
    case (btype)
      3'b001:  cmp_result = (rs == rt);
      3'b010:  cmp_result = (rs != rt);
      3'b011:  cmp_result = rs_neg || rs_zero;
      3'b100:  cmp_result = !rs_neg && !rs_zero;
      3'b101:  cmp_result = rs_neg;
      3'b110:  cmp_result = !rs_neg;
      default: cmp_result = 1'b0;
    endcase
  end

  assign cur_entry  = bht[idx];
  assign pred_taken = d_valid && is_br && cur_entry[1];

  always_comb begin
    next_entry = cur_entry;
    case (cur_entry)
      SN:      next_entry = cmp_result ? WN : SN;
      WN:      next_entry = cmp_result ? WT : SN;
      WT:      next_entry = cmp_result ? ST : WN;
      ST:      next_entry = cmp_result ? ST : WT;
      default: next_entry = WN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= WN;
      end
    end else if (upd) begin
      bht[idx] <= next_entry;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= upd && (pred_taken != cmp_result);
      if (upd && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (upd && (pred_taken != cmp_result) && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_d_branch_unit.sv
// Self-checking bench for d_branch_unit: table-driven compare sweep, directed
// corner sequences and randomized traffic against a counter-table model.
module tb_d_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic        stall;
  logic [31:0] d_pc;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [2:0]  btype;

  logic        cmp_result, pred_taken, mispredict;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        cmp_result4, pred_taken4, mispredict4;
  logic [3:0]  branch_cnt4, mispred_cnt4;

  always #5 clk = ~clk;

  d_branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .stall(stall), .d_pc(d_pc),
    .rs(rs), .rt(rt), .btype(btype), .cmp_result(cmp_result),
    .pred_taken(pred_taken), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  d_branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .stall(stall), .d_pc(d_pc),
    .rs(rs), .rt(rt), .btype(btype), .cmp_result(cmp_result4),
    .pred_taken(pred_taken4), .mispredict(mispredict4),
    .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: counter values 0..3 and unbounded counts, clamped when compared.
  int     m_bht [16];
  longint m_bcnt;
  longint m_mcnt;
  bit     m_mis;

  typedef struct {
    logic [2:0]  bt;
    logic [31:0] a;
    logic [31:0] b;
    int          exp;
  } cmp_vec_t;

  function automatic bit ref_cmp(logic [2:0] bt, logic [31:0] a, logic [31:0] b);
    longint sa;
    sa = longint'($signed(a));
    case (bt)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return sa <= 0;
      3'd4:    return sa > 0;
      3'd5:    return sa < 0;
      3'd6:    return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint clamp(longint v, longint top);
    return (v > top) ? top : v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
    m_mis  = 1'b0;
  endtask

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic applyStimulus(input bit rst_n, input bit v, input bit st,
                               input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] bt,
                               input int exp_cmp);
    bit is_br, exp_c, exp_p;
    int idx;
    reset = rst_n; d_valid = v; stall = st; d_pc = pc; rs = a; rt = b; btype = bt;
    #1;
    is_br = (bt >= 3'd1) && (bt <= 3'd6);
    idx   = int'(pc[5:2]);
    exp_c = ref_cmp(bt, a, b);
    exp_p = v && is_br && (m_bht[idx] >= 2);
    checkOutput("cmp_result", {63'd0, cmp_result}, {63'd0, exp_c});
    if (exp_cmp >= 0) checkOutput("cmp_table", {63'd0, cmp_result}, 64'(exp_cmp));
    checkOutput("pred_taken", {63'd0, pred_taken}, {63'd0, exp_p});
    checkOutput("pred_taken4", {63'd0, pred_taken4}, {63'd0, exp_p});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (v && !st && is_br) begin
      m_mis = (exp_p != exp_c);
      m_bcnt++;
      if (m_mis) m_mcnt++;
      m_bht[idx] = exp_c ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                         : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
    end else begin
      m_mis = 1'b0;
    end
    #1;
    checkOutput("mispredict", {63'd0, mispredict}, {63'd0, m_mis});
    checkOutput("mispredict4", {63'd0, mispredict4}, {63'd0, m_mis});
    checkOutput("branch_cnt", {32'd0, branch_cnt}, 64'(clamp(m_bcnt, 64'hFFFF_FFFF)));
    checkOutput("mispred_cnt", {32'd0, mispred_cnt}, 64'(clamp(m_mcnt, 64'hFFFF_FFFF)));
    checkOutput("branch_cnt4", {60'd0, branch_cnt4}, 64'(clamp(m_bcnt, 15)));
    checkOutput("mispred_cnt4", {60'd0, mispred_cnt4}, 64'(clamp(m_mcnt, 15)));
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, -1);
  endtask

  cmp_vec_t sweep [7];

  initial begin
    sweep[0] = '{3'd1, 32'd5,         32'd5, 1};
    sweep[1] = '{3'd2, 32'd5,         32'd5, 0};
    sweep[2] = '{3'd3, 32'd0,         32'd9, 1};
    sweep[3] = '{3'd4, 32'd0,         32'd9, 0};
    sweep[4] = '{3'd5, 32'h8000_0000, 32'd0, 1};
    sweep[5] = '{3'd6, 32'h7FFF_FFFF, 32'd0, 1};
    sweep[6] = '{3'd7, 32'd5,         32'd5, 0};

    model_reset();
    do_reset();
    checkOutput("reset_branch_cnt", {32'd0, branch_cnt}, 64'd0);
    checkOutput("reset_mispredict", {63'd0, mispredict}, 64'd0);
    for (int p = 0; p < 4; p++)
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000 + 32'(p * 4), 32'd1, 32'd1, 3'd1, -1);

    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, sweep[i].a, sweep[i].b, sweep[i].bt, sweep[i].exp);

    // Repeated taken beq: one mispredict on the WN entry, then saturate at ST.
    do_reset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h3004, 32'd5, 32'd5, 3'd1, 1);
    checkOutput("t3_branch_cnt", {32'd0, branch_cnt}, 64'd4);
    checkOutput("t3_mispred_cnt", {32'd0, mispred_cnt}, 64'd1);

    // Stalled branch updates only once, when stall drops.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3008, 32'd1, 32'd1, 3'd1, -1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3008, 32'd1, 32'd1, 3'd1, -1);
    checkOutput("t4_branch_cnt", {32'd0, branch_cnt}, 64'd5);
    checkOutput("t4_mispredict", {63'd0, mispredict}, 64'd1);

    // 0x3000 and 0x3040 alias onto the same entry.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000, 32'd7, 32'd7, 3'd1, -1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000, 32'd7, 32'd7, 3'd1, -1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3040, 32'd1, 32'd2, 3'd1, -1);
    checkOutput("t5_alias_pred", {63'd0, pred_taken}, 64'd1);

    // Reset with trained entries, then read back a few of them.
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3004, 32'd5, 32'd5, 3'd1, -1);
    checkOutput("t6_pred_after_reset", {63'd0, pred_taken}, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000, 32'd5, 32'd5, 3'd1, -1);

    // Alternating outcomes mispredict every time; CNT_W=4 counters stick at 15.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'd3, (i % 2 == 0) ? 32'd3 : 32'd4, 3'd1, -1);
    checkOutput("t6_branch_cnt4_sat", {60'd0, branch_cnt4}, 64'd15);
    checkOutput("t6_mispred_cnt4_sat", {60'd0, mispred_cnt4}, 64'd15);
    checkOutput("t6_branch_cnt32", {32'd0, branch_cnt}, 64'd20);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] vals [4];
      vals[0] = 32'd0; vals[1] = 32'd5; vals[2] = 32'h8000_0000; vals[3] = 32'h7FFF_FFFF;
      applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, 32'h4000 + 32'($urandom_range(0, 31)),
                    vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)],
                    3'($urandom_range(0, 7)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
